// File: rtl/sobel_pkg.sv
// Shared constants, FSM state type and small index helpers for the Sobel
// line-buffer scheduler.
package sobel_pkg;

    localparam int NUM_RAMS = 12;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int ORDER_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    function automatic logic [1:0] mod3_inc(input logic [1:0] r);
        return (r == 2'd2) ? 2'd0 : r + 2'd1;
    endfunction

    // row is y mod 4, taken as the two LSBs of the line counter
    function automatic logic [ORDER_W-1:0] ram_idx(input logic [1:0] row,
                                                   input logic [1:0] col);
        return ORDER_W'(row) * ORDER_W'(NUM_COLS) + ORDER_W'(col);
    endfunction

endpackage

// File: rtl/mod3_counter.sv
// Incrementing column counter that tracks value mod 3 and value / 3
// without a divider; clears synchronously on clr_i or on an increment at wrap.
module mod3_counter
    import sobel_pkg::*;
#(
    parameter int VW = 8,
    parameter int QW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          wrap_i,
    output logic [VW-1:0] val_o,
    output logic [1:0]    rem_o,
    output logic [QW-1:0] quo_o
);

    logic [VW-1:0] val_q, val_d;
    logic [1:0]    rem_q, rem_d;
    logic [QW-1:0] quo_q, quo_d;

    always_comb begin
        val_d = val_q;
        rem_d = rem_q;
        quo_d = quo_q;
        if (clr_i || (inc_i && wrap_i)) begin
            val_d = '0;
            rem_d = '0;
            quo_d = '0;
        end else if (inc_i) begin
            val_d = val_q + VW'(1);
            rem_d = mod3_inc(rem_q);
            if (rem_q == 2'd2) begin
                quo_d = quo_q + QW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            val_q <= val_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign val_o = val_q;
    assign rem_o = rem_q;
    assign quo_o = quo_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Line-buffer write scheduler and 3x3 window read issuer for the Sobel
// pipeline: 4 line rows x 3 column banks, one window issued per cycle.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 6,
    parameter int CW     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_pixel,
    output logic                in_ready,
    output logic [NUM_RAMS-1:0] wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [7:0]          wr_data,
    output logic [ADDR_W-1:0]   rd_addr0,
    output logic [ADDR_W-1:0]   rd_addr1,
    output logic [ADDR_W-1:0]   rd_addr2,
    output logic [ORDER_W-1:0]  order,
    output logic                win_valid,
    output logic [CW-1:0]       win_x,
    output logic [CW-1:0]       win_y,
    output logic                busy,
    output logic                frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [YW:0] H_L = (YW + 1)'(IMG_H);

    state_t state_q, state_d;
    logic   drain_q, drain_d;

    logic [XW-1:0]     wx_val, rx_val;
    logic [1:0]        wx_rem, rx_rem;
    logic [ADDR_W-1:0] wx_quo, rx_quo;
    logic [YW-1:0]     wy_q, wy_d, ry_q, ry_d;
    logic [YW:0]       wy_ext, ry_p3, ry_p4;

    logic clr, accept, issue, w_wrap, r_wrap, last_issue, ready_w;

    logic [NUM_RAMS-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;

    // Pipeline: stage 1 = RAM address, stage 2 = RAM data/order, stage 3 = window out
    logic                v1_q, v2_q, v3_q, last1_q, last2_q, done_q;
    logic [ADDR_W-1:0]   rd0_q, rd1_q, rd2_q, rd0_d, rd1_d, rd2_d;
    logic [ORDER_W-1:0]  ord1_q, order_q;
    logic [CW-1:0]       x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;

    assign wy_ext = {1'b0, wy_q};
    assign ry_p3  = {1'b0, ry_q} + (YW + 1)'(3);
    assign ry_p4  = {1'b0, ry_q} + (YW + 1)'(4);

    assign clr        = (state_q == IDLE) && start;
    assign ready_w    = (state_q == RUN) && (wy_ext < H_L) && (wy_ext < ry_p4);
    assign accept     = in_valid && ready_w;
    assign issue      = (state_q == RUN) && (wy_ext >= ry_p3);
    assign w_wrap     = (wx_val == XW'(IMG_W - 1));
    assign r_wrap     = (rx_val == XW'(IMG_W - 3));
    assign last_issue = issue && r_wrap && (ry_q == YW'(IMG_H - 3));

    mod3_counter #(.VW(XW), .QW(ADDR_W)) u_wcol (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (accept),
        .wrap_i (w_wrap),
        .val_o  (wx_val),
        .rem_o  (wx_rem),
        .quo_o  (wx_quo)
    );

    mod3_counter #(.VW(XW), .QW(ADDR_W)) u_rcol (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (issue),
        .wrap_i (r_wrap),
        .val_o  (rx_val),
        .rem_o  (rx_rem),
        .quo_o  (rx_quo)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = IDLE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wy_d      = wy_q;
        ry_d      = ry_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (clr) begin
            wy_d = '0;
            ry_d = '0;
        end else begin
            if (accept && w_wrap) wy_d = wy_q + YW'(1);
            if (issue && r_wrap)  ry_d = ry_q + YW'(1);
        end
        if (accept) begin
            wr_en_d[ram_idx(wy_q[1:0], wx_rem)] = 1'b1;
            wr_addr_d = wx_quo;
            wr_data_d = in_pixel;
        end
        // Bank m reads word (rx + ((m - c) mod 3)) / 3: quotient, plus one when m < c
        rd0_d = (rx_rem == 2'd0) ? rx_quo : rx_quo + ADDR_W'(1);
        rd1_d = (rx_rem <= 2'd1) ? rx_quo : rx_quo + ADDR_W'(1);
        rd2_d = rx_quo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_q   <= 1'b0;
            wy_q      <= '0;
            ry_q      <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
            done_q    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ord1_q    <= '0;
            order_q   <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            x3_q      <= '0;
            y3_q      <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wy_q      <= wy_d;
            ry_q      <= ry_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            v1_q      <= issue;
            last1_q   <= last_issue;
            if (issue) begin
                rd0_q  <= rd0_d;
                rd1_q  <= rd1_d;
                rd2_q  <= rd2_d;
                ord1_q <= ram_idx(ry_q[1:0], rx_rem);
                x1_q   <= CW'(rx_val) + CW'(1);
                y1_q   <= CW'(ry_q) + CW'(1);
            end
            v2_q    <= v1_q;
            last2_q <= v1_q && last1_q;
            if (v1_q) begin
                order_q <= ord1_q;
                x2_q    <= x1_q;
                y2_q    <= y1_q;
            end
            v3_q   <= v2_q;
            done_q <= v2_q && last2_q;
            if (v2_q) begin
                x3_q <= x2_q;
                y3_q <= y2_q;
            end
        end
    end

    assign in_ready   = ready_w;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_addr0   = rd0_q;
    assign rd_addr1   = rd1_q;
    assign rd_addr2   = rd2_q;
    assign order      = order_q;
    assign win_valid  = v3_q;
    assign win_x      = x3_q;
    assign win_y      = y3_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 image with a scoreboard of
// expected RAM addresses, order codes and windows keyed by due cycle.
module tb_sobel_window_ctrl;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int AW    = 6;
    localparam int CWL   = 8;
    localparam int WPR   = W - 2;
    localparam int TOTAL = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [7:0]    in_pixel;
    logic          in_ready, win_valid, busy, frame_done;
    logic [11:0]   wr_en;
    logic [AW-1:0] wr_addr, rd_addr0, rd_addr1, rd_addr2;
    logic [7:0]    wr_data;
    logic [3:0]    order;
    logic [CWL-1:0] win_x, win_y;

    always #5 clk = ~clk;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CW(CWL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .order      (order),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        int due;
        int v0;
        int v1;
        int v2;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   running;
    int   acc, iss, drain_end, nwin;
    logic [11:0]   pend_en;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_data;
    logic [3:0]    exp_order;
    exp_t rdq[$], ordq[$], winq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        running   = 1'b0;
        acc       = 0;
        iss       = 0;
        drain_end = 0;
        pend_en   = '0;
        pend_addr = '0;
        pend_data = '0;
        exp_order = '0;
        rdq.delete();
        ordq.delete();
        winq.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_addr0"}, rd_addr0, 0);
        chk({tag, "_rd_addr1"}, rd_addr1, 0);
        chk({tag, "_rd_addr2"}, rd_addr2, 0);
        chk({tag, "_order"}, order, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_x"}, win_x, 0);
        chk({tag, "_win_y"}, win_y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // One clock: predict from current model state and inputs, clock, then score outputs.
    task automatic step();
        int   lines, rows, rx, ry, c;
        bit   exp_ready, issue, busy_now, exp_v;
        exp_t e;
        lines     = acc / W;
        rows      = iss / WPR;
        busy_now  = running || (cyc < drain_end);
        exp_ready = running && (lines < H) && (lines < rows + 4);
        chk("in_ready", in_ready, exp_ready);
        issue = running && (iss < TOTAL) && (lines >= rows + 3);
        pend_en = '0;
        if (in_valid && exp_ready) begin
            pend_en[((lines % 4) * 3) + ((acc % W) % 3)] = 1'b1;
            pend_addr = AW'((acc % W) / 3);
            pend_data = in_pixel;
            acc++;
        end
        if (issue) begin
            rx = iss % WPR;
            ry = rows;
            c  = rx % 3;
            e.due = cyc + 1;
            e.v0  = (rx + ((3 - c) % 3)) / 3;
            e.v1  = (rx + ((4 - c) % 3)) / 3;
            e.v2  = (rx + ((5 - c) % 3)) / 3;
            rdq.push_back(e);
            e.due = cyc + 2;
            e.v0  = (ry % 4) * 3 + c;
            e.v1  = 0;
            e.v2  = 0;
            ordq.push_back(e);
            e.due = cyc + 3;
            e.v0  = rx + 1;
            e.v1  = ry + 1;
            e.v2  = (iss == TOTAL - 1) ? 1 : 0;
            winq.push_back(e);
            iss++;
            if (iss == TOTAL) begin
                running   = 1'b0;
                drain_end = cyc + 3;
            end
        end
        if (start && !busy_now) begin
            running = 1'b1;
            acc     = 0;
            iss     = 0;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;

        chk("busy", busy, running || (cyc < drain_end));
        chk("wr_en", wr_en, pend_en);
        if (pend_en != '0) begin
            chk("wr_addr", wr_addr, pend_addr);
            chk("wr_data", wr_data, pend_data);
        end
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            chk("rd_addr0", rd_addr0, rdq[0].v0);
            chk("rd_addr1", rd_addr1, rdq[0].v1);
            chk("rd_addr2", rd_addr2, rdq[0].v2);
            void'(rdq.pop_front());
        end
        if (ordq.size() > 0 && ordq[0].due == cyc) begin
            exp_order = 4'(ordq[0].v0);
            void'(ordq.pop_front());
        end
        chk("order", order, exp_order);
        exp_v = (winq.size() > 0) && (winq[0].due == cyc);
        chk("win_valid", win_valid, exp_v);
        if (exp_v) begin
            chk("win_x", win_x, winq[0].v0);
            chk("win_y", win_y, winq[0].v1);
            chk("frame_done", frame_done, winq[0].v2);
            void'(winq.pop_front());
        end else begin
            chk("frame_done_idle", frame_done, 0);
        end
        if (win_valid === 1'b1) nwin++;
        in_pixel = 8'($urandom);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        nwin     = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst      = 1'b0;
        in_valid = 1'b1;

        // Abandoned frame: asynchronous reset after 10 accepted pixels
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && acc < 10; i++) step();
        chk("pre_reset_accepts", dut.u_wcol.val_o, 3'd2);
        #2 rst = 1'b1;
        #1 check_zero("reset_mid");
        model_clear();
        @(negedge clk);
        rst = 1'b0;

        // Full frame, in_valid held high, with a start pulse while busy
        nwin  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 300 && (running || cyc < drain_end); i++) begin
            start = (i == 20);
            step();
        end
        start = 1'b0;
        chk("frame1_windows", nwin, TOTAL);
        repeat (5) step();

        // Second frame with random input gaps
        nwin  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 600 && (running || cyc < drain_end); i++) begin
            in_valid = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b1;
        chk("frame2_windows", nwin, TOTAL);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
